// File: rtl/nand_logic_pipe_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
// The op encoding lives here so that producers and the unit agree on it.
package nand_logic_pipe_pkg;

    // Op select encoding; NAND is op 0 so an all-zero OP behaves like the old gate
    typedef enum logic [2:0] {
        OP_NAND  = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_t;

    localparam int OP_W = 3;

    // One-bit evaluation of the selected op; the top applies it per bit lane.
    // B is ignored for OP_NOTA and OP_PASSA.
    function automatic logic logic_eval(input logic a, input logic b, input op_t op);
        logic result;
        case (op)
            OP_NAND:  result = ~(a & b);
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NOR:   result = ~(a | b);
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NOTA:  result = ~a;
            OP_PASSA: result = a;
            default:  result = ~(a & b);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/nand_logic_pipe_stage.sv
// One valid/ready register stage of the logic pipe.
// The stage's ready is computed by the top from the downstream valids, so the
// stage itself only needs to know whether it may load this cycle.
module nlp_stage #(
    parameter int PAY_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic             up_valid,
    input  logic [PAY_W-1:0] up_pay,
    output logic             valid,
    output logic [PAY_W-1:0] pay
);

    // Load upstream valid and payload when ready, otherwise hold; reset clears both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pay   <= '0;
        end else if (ready) begin
            valid <= up_valid;
            pay   <= up_pay;
        end
    end

endmodule

// File: rtl/nand_logic_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready flow control,
// zero/all-ones result flags and a wrapping count of delivered results.
// Optional feature: define NLP_PARITY_EN to add the Y_PARITY output (^Y),
// which is computed up front and travels down the pipe with the flags.
module nand_logic_pipe
    import nand_logic_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [OP_W-1:0]    OP,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   Y,
    output logic               Y_ZERO,
    output logic               Y_ONES,
    output logic               Y_VALID,
    input  logic               Y_READY,
`ifdef NLP_PARITY_EN
    output logic               Y_PARITY,
`endif
    output logic [COUNT_W-1:0] OUT_COUNT
);

`ifdef NLP_PARITY_EN
    localparam int FLAG_W = 3;
`else
    localparam int FLAG_W = 2;
`endif
    localparam int PAY_W = WIDTH + FLAG_W;

    // Payload layout, LSB first: result, zero flag, ones flag, then parity if present
    localparam int ZERO_BIT = WIDTH;
    localparam int ONES_BIT = WIDTH + 1;

    logic [WIDTH-1:0]  y_new;
    logic [PAY_W-1:0]  pay_new;
    logic [STAGES-1:0] vld;
    logic [PAY_W-1:0]  pay [STAGES];
    logic [STAGES:0]   rdy;
    logic [PAY_W-1:0]  pay_last;

    // Evaluate the selected op lane by lane on the incoming operands
    always_comb begin
        y_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y_new[i] = logic_eval(A[i], B[i], op_t'(OP));
        end
    end

`ifdef NLP_PARITY_EN
    assign pay_new = {^y_new, &y_new, ~|y_new, y_new};
`else
    assign pay_new = {&y_new, ~|y_new, y_new};
`endif

    // A stage may load when it is empty or everything below it can move; this is
    // written from the valids so ready never depends on IN_VALID
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = Y_READY;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~vld[i] | rdy[i+1];
        end
    end

    assign IN_READY = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_v;
        logic [PAY_W-1:0] up_p;

        if (i == 0) begin : g_first
            assign up_v = IN_VALID;
            assign up_p = pay_new;
        end else begin : g_next
            assign up_v = vld[i-1];
            assign up_p = pay[i-1];
        end

        nlp_stage #(
            .PAY_W(PAY_W)
        ) u_stage (
            .clk     (CLK),
            .rst     (RST),
            .ready   (rdy[i]),
            .up_valid(up_v),
            .up_pay  (up_p),
            .valid   (vld[i]),
            .pay     (pay[i])
        );
    end

    assign pay_last = pay[STAGES-1];
    assign Y_VALID  = vld[STAGES-1];
    assign Y        = pay_last[WIDTH-1:0];
    assign Y_ZERO   = Y_VALID & pay_last[ZERO_BIT];
    assign Y_ONES   = Y_VALID & pay_last[ONES_BIT];
`ifdef NLP_PARITY_EN
    assign Y_PARITY = Y_VALID & pay_last[ONES_BIT+1];
`endif

    // Count every output handshake; wraps naturally at 2^COUNT_W
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_COUNT <= '0;
        end else if (Y_VALID && Y_READY) begin
            OUT_COUNT <= OUT_COUNT + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nand_logic_pipe.sv
// Self-checking bench for nand_logic_pipe.
// Two instances share clock and reset: a WIDTH=1 unit for the op truth-table
// sweep and a WIDTH=8, COUNT_W=4 unit for flags, flow control and counter wrap.
// Parity is only checked when NLP_PARITY_EN is defined.
module tb_nand_logic_pipe;

    typedef struct packed {
        logic       narrow;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       zero;
        logic       ones;
        logic       parity;
    } vec_t;

    logic clk;
    logic rst;

    logic        a1, b1;
    logic [2:0]  op1;
    logic        in_valid1, in_ready1;
    logic        y1, zero1, ones1, y_valid1, y_ready1;
    logic [15:0] count1;

    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        in_valid8, in_ready8;
    logic [7:0]  y8;
    logic        zero8, ones8, y_valid8, y_ready8;
    logic [3:0]  count8;

`ifdef NLP_PARITY_EN
    logic        parity1, parity8;
`endif

    int          checks;
    int          errors;
    logic [15:0] exp_count1;
    logic [3:0]  exp_count8;
    vec_t        vecs [$];

    nand_logic_pipe #(.WIDTH(1), .STAGES(2), .COUNT_W(16)) u_w1 (
        .CLK(clk), .RST(rst), .A(a1), .B(b1), .OP(op1),
        .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .Y(y1), .Y_ZERO(zero1), .Y_ONES(ones1), .Y_VALID(y_valid1), .Y_READY(y_ready1),
`ifdef NLP_PARITY_EN
        .Y_PARITY(parity1),
`endif
        .OUT_COUNT(count1)
    );

    nand_logic_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(4)) u_w8 (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .OP(op8),
        .IN_VALID(in_valid8), .IN_READY(in_ready8),
        .Y(y8), .Y_ZERO(zero8), .Y_ONES(ones8), .Y_VALID(y_valid8), .Y_READY(y_ready8),
`ifdef NLP_PARITY_EN
        .Y_PARITY(parity8),
`endif
        .OUT_COUNT(count8)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic addVec8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] y, input logic zero, input logic ones,
                           input logic parity);
        vec_t v;
        v.narrow = 1'b0;
        v.op     = op;
        v.a      = a;
        v.b      = b;
        v.y      = y;
        v.zero   = zero;
        v.ones   = ones;
        v.parity = parity;
        vecs.push_back(v);
    endtask

    // Push one vector, confirm nothing appears after one edge and the result
    // appears after the second; the result pops on the following edge.
    task automatic applyStimulus(input vec_t v);
        y_ready1 = 1'b1;
        y_ready8 = 1'b1;
        if (v.narrow) begin
            a1 = v.a[0];
            b1 = v.b[0];
            op1 = v.op;
            in_valid1 = 1'b1;
        end else begin
            a8 = v.a;
            b8 = v.b;
            op8 = v.op;
            in_valid8 = 1'b1;
        end
        #1;
        checkOutput("in_ready", v.narrow ? in_ready1 : in_ready8, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid8 = 1'b0;
        #1;
        checkOutput("latency_early", v.narrow ? y_valid1 : y_valid8, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        if (v.narrow) begin
            checkOutput("w1_valid", y_valid1, 1);
            checkOutput("w1_y", y1, v.y[0]);
            checkOutput("w1_zero", zero1, v.zero);
            checkOutput("w1_ones", ones1, v.ones);
`ifdef NLP_PARITY_EN
            checkOutput("w1_parity", parity1, v.parity);
`endif
            exp_count1 = exp_count1 + 16'd1;
        end else begin
            checkOutput("w8_valid", y_valid8, 1);
            checkOutput("w8_y", y8, v.y);
            checkOutput("w8_zero", zero8, v.zero);
            checkOutput("w8_ones", ones8, v.ones);
`ifdef NLP_PARITY_EN
            checkOutput("w8_parity", parity8, v.parity);
`endif
            exp_count8 = exp_count8 + 4'd1;
        end
    endtask

    initial begin
        logic [3:0] truth [8];
        logic [1:0] ab;
        logic [7:0] bp_a [6];
        logic [2:0] bp_op [6];
        logic [7:0] bp_y [6];
        vec_t       v;
        int         next_in;
        int         got;
        logic       push;

        checks = 0;
        errors = 0;
        exp_count1 = '0;
        exp_count8 = '0;
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; op1 = 3'd0; in_valid1 = 1'b0; y_ready1 = 1'b1;
        a8 = '0; b8 = '0; op8 = 3'd0; in_valid8 = 1'b0; y_ready8 = 1'b1;

        // Truth tables indexed by {a,b}: bit0 = 00, bit1 = 01, bit2 = 10, bit3 = 11
        truth[0] = 4'b0111;
        truth[1] = 4'b1000;
        truth[2] = 4'b1110;
        truth[3] = 4'b0001;
        truth[4] = 4'b0110;
        truth[5] = 4'b1001;
        truth[6] = 4'b0011;
        truth[7] = 4'b1100;
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 4; k++) begin
                ab       = 2'(k);
                v.narrow = 1'b1;
                v.op     = 3'(op);
                v.a      = {7'b0, ab[1]};
                v.b      = {7'b0, ab[0]};
                v.y      = {7'b0, truth[op][ab]};
                v.zero   = ~truth[op][ab];
                v.ones   = truth[op][ab];
                v.parity = truth[op][ab];
                vecs.push_back(v);
            end
        end
        addVec8(3'd0, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
        addVec8(3'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        addVec8(3'd2, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1, 1'b0);
        addVec8(3'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        addVec8(3'd4, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b0);
        addVec8(3'd5, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);
        addVec8(3'd6, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0);
        addVec8(3'd7, 8'h3C, 8'h99, 8'h3C, 1'b0, 1'b0, 1'b0);
        addVec8(3'd7, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1);
        addVec8(3'd0, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0, 1'b0);
        addVec8(3'd7, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);

        bp_a[0] = 8'hF0; bp_op[0] = 3'd0; bp_y[0] = 8'hCF;
        bp_a[1] = 8'hF0; bp_op[1] = 3'd1; bp_y[1] = 8'h30;
        bp_a[2] = 8'hF0; bp_op[2] = 3'd2; bp_y[2] = 8'hFC;
        bp_a[3] = 8'hF0; bp_op[3] = 3'd4; bp_y[3] = 8'hCC;
        bp_a[4] = 8'h5A; bp_op[4] = 3'd6; bp_y[4] = 8'hA5;
        bp_a[5] = 8'h5A; bp_op[5] = 3'd7; bp_y[5] = 8'h5A;

        // Reset state
        #2;
        checkOutput("rst_valid", y_valid8, 0);
        checkOutput("rst_y", y8, 0);
        checkOutput("rst_zero", zero8, 0);
        checkOutput("rst_ones", ones8, 0);
        checkOutput("rst_count", count8, 0);
        checkOutput("rst_in_ready", in_ready8, 1);
        checkOutput("rst_w1_valid", y_valid1, 0);
        idle(2);
        rst = 1'b0;

        // Table sweep
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end
        idle(1);
        checkOutput("w1_count_after_table", count1, exp_count1);
        checkOutput("w8_count_after_table", count8, exp_count8);

        // Backpressure: fill, stall with a full pipe, release and drain in order
        next_in = 0;
        got = 0;
        b8 = 8'h3C;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (next_in < 6) begin
                a8 = bp_a[next_in];
                op8 = bp_op[next_in];
                in_valid8 = 1'b1;
            end else begin
                in_valid8 = 1'b0;
            end
            y_ready8 = (cyc >= 7);
            #1;
            if (cyc >= 2 && cyc < 7) begin
                checkOutput("bp_in_ready_low", in_ready8, 0);
                checkOutput("bp_held_valid", y_valid8, 1);
                checkOutput("bp_held_y", y8, bp_y[0]);
            end
            if (y_valid8 && y_ready8) begin
                checkOutput("bp_order_y", y8, bp_y[got]);
                got++;
            end
            push = in_valid8 & in_ready8;
            @(posedge clk);
            if (push) next_in++;
        end
        checkOutput("bp_delivered", got, 6);
        exp_count8 = exp_count8 + 4'(got);
        @(negedge clk);
        in_valid8 = 1'b0;
        idle(2);
        checkOutput("bp_no_duplicate", y_valid8, 0);
        checkOutput("bp_count", count8, exp_count8);

        // Full pipe with simultaneous push and pop for 10 cycles
        y_ready8 = 1'b0;
        op8 = 3'd7;
        for (int k = 0; k < 2; k++) begin
            a8 = 8'h20 + 8'(k);
            in_valid8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            y_ready8 = 1'b1;
            a8 = 8'h22 + 8'(k);
            in_valid8 = 1'b1;
            #1;
            checkOutput("fp_in_ready", in_ready8, 1);
            checkOutput("fp_valid", y_valid8, 1);
            checkOutput("fp_y", y8, 8'h20 + 8'(k));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        #1;
        checkOutput("fp_count_plus10", count8, exp_count8 + 4'd10);
        checkOutput("fp_tail0", y8, 8'h2A);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("fp_tail1", y8, 8'h2B);
        @(posedge clk);
        @(negedge clk);
        exp_count8 = exp_count8 + 4'd12;
        checkOutput("fp_count_drained", count8, exp_count8);

        // Asynchronous reset with two items in flight
        y_ready8 = 1'b1;
        op8 = 3'd7;
        a8 = 8'h40;
        in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h41;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        y_ready8 = 1'b0;
        #1;
        checkOutput("pre_rst_valid", y_valid8, 1);
        checkOutput("pre_rst_y", y8, 8'h40);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", y_valid8, 0);
        checkOutput("async_rst_y", y8, 0);
        checkOutput("async_rst_count", count8, 0);
        checkOutput("async_rst_w1_count", count1, 0);
        exp_count8 = '0;
        exp_count1 = '0;
        @(negedge clk);
        rst = 1'b0;
        v.narrow = 1'b0; v.op = 3'd7; v.a = 8'h5C; v.b = 8'h00;
        v.y = 8'h5C; v.zero = 1'b0; v.ones = 1'b0; v.parity = 1'b0;
        applyStimulus(v);

        // Counter wrap: 16 more deliveries on a 4-bit counter makes 17 in total
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            y_ready8 = 1'b1;
            a8 = 8'(k);
            in_valid8 = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        idle(3);
        checkOutput("wrap_count", count8, 4'd1);
        checkOutput("wrap_drained", y_valid8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
